// File: rtl/lsu_dmem_ctrl.sv
// M-stage load/store controller: alignment check, strobe/lane build,
// valid/ready request plus response handshake with data memory.
module lsu_dmem_ctrl #(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemReadM,
  input  logic                      MemWriteM,
  input  logic [2:0]                Funct3M,
  input  logic [XLEN-1:0]           ALUResultM,
  input  logic [XLEN-1:0]           WriteDataM,
  output logic                      dmem_req_valid,
  input  logic                      dmem_req_ready,
  output logic                      dmem_we,
  output logic [XLEN-1:0]           dmem_addr,
  output logic [XLEN-1:0]           dmem_wdata,
  output logic [XLEN/8-1:0]         dmem_wstrb,
  input  logic                      dmem_rsp_valid,
  input  logic [XLEN-1:0]           dmem_rsp_rdata,
  output logic [XLEN-1:0]           RD_data,
  output logic [$clog2(XLEN/8)-1:0] byteAddrM,
  output logic                      StallM,
  output logic                      LoadMisalignM,
  output logic                      StoreMisalignM
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  if (XLEN != 32) begin : g_xlen_chk
    $error("lsu_dmem_ctrl: only XLEN=32 is supported");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [OFFW-1:0]   boff_q, boff_d;

  logic              ld_ok, st_ok, mis, op;
  logic [OFFW-1:0]   off;
  logic [NB-1:0]     strb;
  logic [XLEN-1:0]   wrep;

  assign off = ALUResultM[OFFW-1:0];

  always_comb begin
    ld_ok = MemReadM && (Funct3M inside {3'b000, 3'b001, 3'b010,
                                         3'b100, 3'b101});
    st_ok = MemWriteM && (Funct3M inside {3'b000, 3'b001, 3'b010});
    mis   = (Funct3M[1:0] == 2'b01 && off[0]) ||
            (Funct3M[1:0] == 2'b10 && off != '0);
    op    = (ld_ok || st_ok) && !mis;
  end

  // Store data is replicated across lanes; the strobe picks the lane.
  always_comb begin
    strb = '0;
    wrep = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        strb = {{(NB-1){1'b0}}, 1'b1} << off;
        wrep = {NB{WriteDataM[7:0]}};
      end
      2'b01: begin
        strb = {{(NB-2){1'b0}}, 2'b11} << {off[OFFW-1:1], 1'b0};
        wrep = {(NB/2){WriteDataM[15:0]}};
      end
      default: begin
        strb = '1;
        wrep = WriteDataM;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    rdata_d        = rdata_q;
    boff_d         = boff_q;
    StallM         = 1'b0;
    LoadMisalignM  = 1'b0;
    StoreMisalignM = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        LoadMisalignM  = ld_ok && mis;
        StoreMisalignM = st_ok && mis;
        if (op) begin
          StallM  = 1'b1;
          state_d = S_REQ;
          we_d    = st_ok;
          addr_d  = {ALUResultM[XLEN-1:OFFW], {OFFW{1'b0}}};
          wdata_d = st_ok ? wrep : '0;
          wstrb_d = st_ok ? strb : '0;
          boff_d  = off;
        end
      end
      S_REQ: begin
        StallM = 1'b1;
        if (dmem_req_ready) state_d = we_q ? S_DONE : S_RSP;
      end
      S_RSP: begin
        StallM = 1'b1;
        if (dmem_rsp_valid) begin
          rdata_d = dmem_rsp_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      boff_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      boff_q  <= boff_d;
    end
  end

  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign dmem_wstrb     = wstrb_q;
  assign RD_data        = rdata_q;
  assign byteAddrM      = boff_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Randomized bench for lsu_dmem_ctrl against a transaction-level
// reference model; the bench plays the memory side of the handshake.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata, RD_data;
  logic [1:0]  byteAddrM;
  logic        StallM, LoadMisalignM, StoreMisalignM;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_rd;
  logic [1:0]  m_ba;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rsp_rdata(dmem_rsp_rdata),
    .RD_data(RD_data), .byteAddrM(byteAddrM),
    .StallM(StallM), .LoadMisalignM(LoadMisalignM),
    .StoreMisalignM(StoreMisalignM)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic noise();
    dmem_rsp_valid = 1'($urandom % 2);
    dmem_rsp_rdata = $urandom;
    dmem_req_ready = 1'($urandom % 2);
  endtask

  // One M-stage instruction: d = ready wait cycles, lat = rsp latency.
  task automatic do_txn(input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int d,
                        input int lat, input logic [31:0] rdat);
    logic legal, mis, op;
    logic [3:0]  xs;
    logic [31:0] xw;
    int nreq, nrsp, stalls, xstall;
    bit acc, got, fin;
    legal = rd ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) :
            wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : 1'b0;
    mis = (f3[1:0] == 2'd1 && a[0]) ||
          (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    op = legal && !mis;
    case (f3[1:0])
      2'd0: begin xs = 4'd1 << a[1:0]; xw = {4{wd[7:0]}}; end
      2'd1: begin xs = a[1] ? 4'hC : 4'h3; xw = {2{wd[15:0]}}; end
      default: begin xs = 4'hF; xw = wd; end
    endcase
    if (rd) begin xs = 4'h0; xw = 32'h0; end
    xstall = 2 + d + (rd ? lat : 0);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3;
    ALUResultM = a; WriteDataM = wd;
    if (!op) begin
      @(negedge clk);
      chk("noop_stall", 32'(StallM), 32'd0);
      chk("noop_req", 32'(dmem_req_valid), 32'd0);
      chk("ld_misalign", 32'(LoadMisalignM), 32'(legal && mis && rd));
      chk("st_misalign", 32'(StoreMisalignM), 32'(legal && mis && wr));
      noise();
      return;
    end
    m_ba = a[1:0];
    nreq = 0; nrsp = 0; stalls = 0;
    acc = 0; got = 0; fin = 0;
    for (int k = 0; !fin && k < 40; k++) begin
      @(negedge clk);
      if (StallM) stalls++;
      if (k == 0) begin
        chk("idle_stall", 32'(StallM), 32'd1);
        chk("idle_req", 32'(dmem_req_valid), 32'd0);
        noise();
      end else if (!acc) begin
        chk("req_valid", 32'(dmem_req_valid), 32'd1);
        chk("req_we", 32'(dmem_we), 32'(wr));
        chk("req_addr", dmem_addr, {a[31:2], 2'b00});
        chk("req_wstrb", 32'(dmem_wstrb), 32'(xs));
        if (wr) chk("req_wdata", dmem_wdata, xw);
        nreq++;
        acc = (nreq == d + 1);
        dmem_req_ready = acc;
        dmem_rsp_valid = 1'($urandom % 2);
        dmem_rsp_rdata = $urandom;
      end else if (rd && !got) begin
        chk("rsp_req_low", 32'(dmem_req_valid), 32'd0);
        nrsp++;
        got = (nrsp == lat);
        dmem_rsp_valid = got;
        dmem_rsp_rdata = got ? rdat : $urandom;
        dmem_req_ready = 1'($urandom % 2);
      end else begin
        if (rd) m_rd = rdat;
        chk("done_stall", 32'(StallM), 32'd0);
        chk("done_req", 32'(dmem_req_valid), 32'd0);
        chk("done_rd_data", RD_data, m_rd);
        chk("done_byteaddr", 32'(byteAddrM), 32'(m_ba));
        chk("stall_cycles", 32'(stalls), 32'(xstall));
        noise();
        fin = 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    MemReadM = 0; MemWriteM = 0; Funct3M = 0;
    ALUResultM = 0; WriteDataM = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
    m_rd = 0; m_ba = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(dmem_req_valid), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_rd", RD_data, 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);

    do_txn(0, 1, 3'b000, 32'h1003, 32'h123456A5, 0, 1, 0);
    do_txn(1, 0, 3'b010, 32'h2004, 32'h0, 3, 2, 32'hDEADBEEF);
    do_txn(1, 0, 3'b101, 32'h2001, 32'h0, 0, 1, 0);
    do_txn(0, 1, 3'b010, 32'h3002, 32'h55, 0, 1, 0);
    do_txn(0, 1, 3'b001, 32'h40A6, 32'h0000BEEF, 0, 1, 0);
    do_txn(1, 0, 3'b000, 32'h40A7, 32'h0, 0, 1, 32'h11223344);
    do_txn(1, 0, 3'b011, 32'h5000, 32'h0, 0, 1, 0);

    // Reset while the load waits in RSP; late response must be dropped.
    @(posedge clk); #1;
    MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010;
    ALUResultM = 32'h6008;
    dmem_rsp_valid = 0; dmem_req_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; MemReadM = 0; dmem_req_ready = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rsprst_req", 32'(dmem_req_valid), 32'd0);
    chk("rsprst_rd", RD_data, 32'd0);
    chk("rsprst_we", 32'(dmem_we), 32'd0);
    chk("rsprst_ba", 32'(byteAddrM), 32'd0);
    dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rsp_valid = 0;
    chk("late_rsp_rd", RD_data, 32'd0);
    m_rd = 0; m_ba = 0;

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 4);
      do_txn(sel inside {1, 2}, sel inside {3, 4},
             3'($urandom), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
